sra_serial_shifter: RTL
=======================

// Module: sra_serial_shifter
// PURPOSE
// - Sequential arithmetic shifter: loads one signed (N+1)-bit word, shifts it one bit per clock, AMT times.
// - Direction is arithmetic right (sign-fill) or logical left (zero-fill).
// - Front-end stage of the shift-register datapath.
// - Exposes every intermediate step so the bench can print per-step values.
// - valid/ready on both sides.
// PARAMETERS
// - N   8               data is N+1 bits signed, [N:0]
// - AW  $clog2(N+2)     shift-amount width; derived, do not override
// PORTS
// - clk        in   1     rising-edge clock
// - rst        in   1     synchronous, active-high reset
// - in_valid   in   1     upstream presents in_data/in_amt/in_dir
// - in_ready   out  1     block accepts a new word (IDLE only)
// - in_data    in   N+1   signed operand
// - in_amt     in   AW    shift count, 0..N+1 meaningful
// - in_dir     in   1     0 = arithmetic right, 1 = logical left
// - out_valid  out  1     out_data holds final result
// - out_ready  in   1     downstream accepts result
// - out_data   out  N+1   signed result / current shift register
// - step_cnt   out  AW    shifts completed for current word
// - busy       out  1     high in SHIFT or DONE
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge):
//   - state=IDLE; out_data=0; step_cnt=0; out_valid=0; busy=0; in_ready=1 (combinational from IDLE).
//   - rst wins over every other input.
//   - rst mid-SHIFT or mid-DONE discards the word; no out_valid is produced for it.
// - FSM states: IDLE, SHIFT, DONE.
//   - IDLE: in_ready=1. On in_valid, at that edge:
//     - Load reg=in_data, latch dir, step_cnt=0.
//     - Latch remaining=min(in_amt, N+1). Counts above N+1 clamp: result is all-sign (right) or all-zero (left).
//     - Go to SHIFT if clamped amt>0, else DONE.
//   - SHIFT: each cycle reg = dir ? {reg[N-1:0],1'b0} : {reg[N],reg[N:1]}; step_cnt++.
//     - Go to DONE on the cycle step_cnt reaches the clamped amount.
//     - in_valid ignored while in SHIFT.
//   - DONE: out_valid=1. out_data, step_cnt stable until out_ready.
//     - On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle (no same-cycle reload).
// - Latency: load edge to out_valid = amt+1 cycles (amt=0 gives 1 cycle). Throughput: one word per amt+2 cycles minimum.
// - out_data is the live shift register in every state: loaded value, then each intermediate, then final.
// - Arithmetic right shift rounds toward -inf; a negative word never becomes positive.
// - Left shift discards MSBs; overflow is not flagged.
// STRUCTURE
// - Package shift_pkg holds:
//   - typedef enum logic [1:0] {S_IDLE,S_SHIFT,S_DONE} shift_state_t
//   - typedef enum logic {DIR_SRA=1'b0, DIR_SLL=1'b1} shift_dir_t
// - One combinational sub-module shift_step #(N): single-bit shift of reg per dir. Instantiated once, output registered in this block.
// - Single always_ff for state/reg/counters; in_ready/out_valid/busy are decoded combinationally from state.
// TESTING
// - Reset: rst=1 for 2 clk mid-SHIFT -> IDLE, out_data=0, out_valid=0, in_ready=1 next cycle.
// - SRA: in_data=9'b1_1001_0111 (-105), amt=3, dir=0.
//   - Steps: 111001011, 111100101, 111110010.
//   - out_valid 4 cycles after load, out_data=-14.
// - SLL: in_data=9'b1_1001_0111, amt=2, dir=1 -> out_data=9'b0_0101_1100, step_cnt=2.
// - Clamp/boundary, dir=0:
//   - in_data=9'b0_1001_0111 (+151), amt=N -> 0.
//   - in_data=-105, amt=15 -> 9'h1FF; step_cnt=9.
// - amt=0 and backpressure:
//   - amt=0 -> out_valid one cycle after load, out_data=in_data.
//   - Hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0.
//   - Release -> IDLE, next word accepted one cycle later.
// - in_valid held high while busy -> no reload; second word loads only after DONE handshake; results in order.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state/direction types for the serial arithmetic shifter
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } shift_state_t;

    typedef enum logic {
        DIR_SRA = 1'b0,
        DIR_SLL = 1'b1
    } shift_dir_t;

endpackage

// File: rtl/sra_serial_shifter_if.sv
// rtl/sra_serial_shifter_if.sv - load/result handshake bundle for the serial shifter
interface sra_serial_shifter_if #(
    parameter int N = 8
);
    localparam int AW = $clog2(N + 2);

    logic          in_valid;
    logic          in_ready;
    logic [N:0]    in_data;
    logic [AW-1:0] in_amt;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    out_data;
    logic [AW-1:0] step_cnt;
    logic          busy;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, step_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, step_cnt, busy
    );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit shift: arithmetic right (sign-fill) or logical left (zero-fill)
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0] data_i,
    input  shift_dir_t dir_i,
    output logic [N:0] data_o
);

    assign data_o = (dir_i == DIR_SLL) ? {data_i[N-1:0], 1'b0}
                                       : {data_i[N], data_i[N:1]};

endmodule

// File: rtl/sra_serial_shifter.sv
// rtl/sra_serial_shifter.sv - serial shifter, one bit per clock, result held until out_ready
module sra_serial_shifter
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sra_serial_shifter_if.slave  bus
);

    localparam int AW = $clog2(N + 2);
    localparam logic [AW-1:0] MAX_AMT = AW'(N + 1);

    shift_state_t  state_q;
    logic [N:0]    data_q;
    logic [AW-1:0] step_q;
    logic [AW-1:0] rem_q;
    shift_dir_t    dir_q;

    logic [N:0]    shifted_d;
    logic [AW-1:0] amt_clamp_d;
    logic [AW-1:0] step_next_d;

    shift_step #(.N(N)) u_step (
        .data_i (data_q),
        .dir_i  (dir_q),
        .data_o (shifted_d)
    );

    // Counts beyond the word width would shift out every bit anyway.
    assign amt_clamp_d = (bus.in_amt > MAX_AMT) ? MAX_AMT : bus.in_amt;
    assign step_next_d = step_q + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            dir_q   <= DIR_SRA;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        data_q  <= bus.in_data;
                        dir_q   <= shift_dir_t'(bus.in_dir);
                        step_q  <= '0;
                        rem_q   <= amt_clamp_d;
                        state_q <= (amt_clamp_d != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    data_q <= shifted_d;
                    step_q <= step_next_d;
                    if (step_next_d == rem_q) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.out_data  = data_q;
    assign bus.step_cnt  = step_q;

endmodule
